// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, status word layout and
// baud defaults common to the TX and RX sides.
package uart_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_EMPTY = 2;
  localparam int STAT_OVF   = 3;
  localparam int STAT_COUNT = 8;

  // 50 MHz system clock / 115200 baud
  localparam int BAUD_DIVIDER_DEFAULT = 434;
  localparam int BAUD_CNT_W           = 20;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrapping pointers and a separate occupancy count.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // storage needs no reset; count gates every read of it
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Memory-mapped 8N1 UART transmitter: bus writes queue bytes, a baud-timed FSM
// drains the queue onto serial_out, bus reads return a status word.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int BAUD_DIVIDER = BAUD_DIVIDER_DEFAULT,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic        mem_instr,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_addr,
  output logic [31:0] mem_rdata,
  output logic        serial_out,
  output logic        busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_e              state_q, state_d;
  logic [BAUD_CNT_W-1:0]  baud_q, baud_d;
  logic [2:0]             bitcnt_q, bitcnt_d;
  logic [7:0]             shifter_q, shifter_d;
  logic                   serial_q, serial_d;
  logic                   ready_q;
  logic                   ovf_q, ovf_d;
  logic                   accept, wr_req, rd_req, bit_end;
  logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]             fifo_dout;
  logic [CW-1:0]          fifo_count;
  logic [31:0]            status;
  logic                   unused_bus;

  assign unused_bus = ^{mem_instr, mem_addr, mem_wdata[31:8]};

  assign accept    = mem_valid & enable & ~ready_q;
  assign wr_req    = accept & (|mem_wstrb);
  assign rd_req    = accept & ~(|mem_wstrb);
  // fullness is judged before any same-cycle pop, so a write while full drops
  assign fifo_push = wr_req & ~fifo_full;
  assign ovf_d     = (wr_req & fifo_full) | (ovf_q & ~rd_req);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .din    (mem_wdata[7:0]),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign bit_end = (baud_q == BAUD_CNT_W'(BAUD_DIVIDER - 1));

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bitcnt_d  = bitcnt_q;
    shifter_d = shifter_q;
    fifo_pop  = 1'b0;
    serial_d  = 1'b1;
    if (state_q != TX_IDLE) baud_d = bit_end ? '0 : baud_q + BAUD_CNT_W'(1);
    case (state_q)
      TX_IDLE: if (!fifo_empty) begin
        fifo_pop  = 1'b1;
        shifter_d = fifo_dout;
        baud_d    = '0;
        state_d   = TX_START;
      end
      TX_START: if (bit_end) begin
        bitcnt_d = '0;
        state_d  = TX_DATA;
      end
      TX_DATA: if (bit_end) begin
        shifter_d = {1'b0, shifter_q[7:1]};
        bitcnt_d  = bitcnt_q + 3'd1;
        if (bitcnt_q == 3'd7) state_d = TX_STOP;
      end
      TX_STOP: if (bit_end) begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shifter_d = fifo_dout;
          state_d   = TX_START;
        end else begin
          state_d = TX_IDLE;
        end
      end
      default: state_d = TX_IDLE;
    endcase
    // line level is decided from the next state so it is registered glitch-free
    case (state_d)
      TX_START: serial_d = 1'b0;
      TX_DATA:  serial_d = shifter_d[0];
      default:  serial_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= TX_IDLE;
      baud_q    <= '0;
      bitcnt_q  <= '0;
      shifter_q <= '0;
      serial_q  <= 1'b1;
      ready_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bitcnt_q  <= bitcnt_d;
      shifter_q <= shifter_d;
      serial_q  <= serial_d;
      ready_q   <= accept;
      ovf_q     <= ovf_d;
    end
  end

  assign busy = ~fifo_empty | (state_q != TX_IDLE);

  always_comb begin
    status                  = '0;
    status[STAT_BUSY]       = busy;
    status[STAT_FULL]       = fifo_full;
    status[STAT_EMPTY]      = fifo_empty;
    status[STAT_OVF]        = ovf_q;
    status[STAT_COUNT +: CW] = fifo_count;
  end

  assign mem_rdata  = enable ? status : '0;
  assign mem_ready  = ready_q;
  assign serial_out = serial_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: vector table, hand sequences for the multi-cycle
// corners, and random bus traffic against a frame-timeline reference model.
module tb_uart_tx_fifo;

  localparam int BD    = 4;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic        clk = 1'b0, resetn = 1'b0;
  logic        enable = 1'b0, mem_valid = 1'b0, mem_instr = 1'b0;
  logic [3:0]  mem_wstrb = 4'h0;
  logic [31:0] mem_wdata = 32'h0, mem_addr = 32'h0;
  logic        mem_ready, serial_out, busy;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  uart_tx_fifo #(.BAUD_DIVIDER(BD), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .enable     (enable),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_instr  (mem_instr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .serial_out (serial_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // reference model: queued bytes, current frame byte and its age in clocks
  logic [7:0] m_q[$];
  logic [7:0] m_cur;
  bit         m_act, m_rdy, m_ovf;
  int         m_t;

  task automatic model_reset();
    m_q.delete();
    m_cur = 8'h00;
    m_act = 1'b0;
    m_rdy = 1'b0;
    m_ovf = 1'b0;
    m_t   = 0;
  endtask

  task automatic model_edge();
    int  sz;
    bit  acc, wr;
    if (!resetn) return;
    sz  = m_q.size();
    acc = mem_valid && enable && !m_rdy;
    wr  = acc && (mem_wstrb != 4'h0);
    if (m_act) begin
      m_t++;
      if (m_t == 10 * BD) m_act = 1'b0;
    end
    if (!m_act && sz > 0) begin
      m_cur = m_q.pop_front();
      m_act = 1'b1;
      m_t   = 0;
    end
    if (wr) begin
      if (sz == DEPTH) m_ovf = 1'b1;
      else m_q.push_back(mem_wdata[7:0]);
    end else if (acc) begin
      m_ovf = 1'b0;
    end
    m_rdy = acc;
  endtask

  function automatic logic exp_serial();
    int k;
    if (!m_act) return 1'b1;
    if (m_t < BD) return 1'b0;
    if (m_t < 9 * BD) begin
      k = (m_t - BD) / BD;
      return m_cur[k];
    end
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    s[0] = m_act || (m_q.size() != 0);
    s[1] = (m_q.size() == DEPTH);
    s[2] = (m_q.size() == 0);
    s[3] = m_ovf;
    s[8 +: CW] = CW'(m_q.size());
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("serial_out", {31'b0, serial_out}, {31'b0, exp_serial()});
    chk("busy", {31'b0, busy}, {31'b0, exp_status()[0]});
    chk("mem_ready", {31'b0, mem_ready}, {31'b0, m_rdy});
    chk("mem_rdata", mem_rdata, enable ? exp_status() : 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic bus_write(input logic [7:0] b);
    enable    = 1'b1;
    mem_valid = 1'b1;
    mem_wstrb = 4'($urandom_range(1, 15));
    mem_wdata = {24'($urandom), b};
    step();
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    step();
  endtask

  task automatic bus_read(output logic [31:0] d);
    enable    = 1'b1;
    mem_valid = 1'b1;
    mem_wstrb = 4'h0;
    #1 d = mem_rdata;
    chk("read_value", d, exp_status());
    step();
    mem_valid = 1'b0;
    step();
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while (busy === 1'b1 && n < max_cyc) begin
      step();
      n++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_timeout: busy=%b after %0d cycles, expected 0", busy, n);
    end
  endtask

  typedef struct {
    logic        en;
    logic        vld;
    logic [3:0]  wstrb;
    logic [7:0]  data;
    logic        exp_ready;
    logic [31:0] exp_rdata;
    logic        exp_serial;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[15];

  initial begin
    logic [31:0] rd;
    logic [7:0]  nb;

    // outputs are checked one edge after each vector's inputs are applied
    vecs[0]  = '{1'b0, 1'b1, 4'h0, 8'h00, 1'b0, 32'h0,   1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 4'hF, 8'h55, 1'b0, 32'h0,   1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 4'h0, 8'h00, 1'b1, 32'h4,   1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 4'h0, 8'h00, 1'b0, 32'h4,   1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 32'h4,   1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 4'h1, 8'h55, 1'b1, 32'h101, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 32'h5,   1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 32'h5,   1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 32'h5,   1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 32'h5,   1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 32'h5,   1'b1, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 32'h5,   1'b1, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 32'h5,   1'b1, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 32'h5,   1'b1, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 32'h5,   1'b0, 1'b1};

    model_reset();
    enable = 1'b1;
    #13;
    chk("rst_serial", {31'b0, serial_out}, 32'h1);
    chk("rst_ready", {31'b0, mem_ready}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_status", mem_rdata, 32'h4);
    @(negedge clk);
    resetn = 1'b1;

    foreach (vecs[i]) begin
      enable    = vecs[i].en;
      mem_valid = vecs[i].vld;
      mem_wstrb = vecs[i].wstrb;
      mem_wdata = {24'h0, vecs[i].data};
      step();
      chk($sformatf("vec%0d_ready", i), {31'b0, mem_ready}, {31'b0, vecs[i].exp_ready});
      chk($sformatf("vec%0d_rdata", i), mem_rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_serial", i), {31'b0, serial_out}, {31'b0, vecs[i].exp_serial});
      chk($sformatf("vec%0d_busy", i), {31'b0, busy}, {31'b0, vecs[i].exp_busy});
    end
    mem_valid = 1'b0;
    wait_idle(200);
    bus_read(rd);
    chk("single_done_status", rd, 32'h4);

    // mem_valid held high: acknowledge only every second cycle
    enable = 1'b1; mem_valid = 1'b1; mem_wstrb = 4'h0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("hold_ready", {31'b0, mem_ready}, (i % 2 == 0) ? 32'h1 : 32'h0);
    end
    mem_valid = 1'b0;
    step();

    // back-to-back frames must abut with no idle clock
    bus_write(8'hA5);
    bus_write(8'h3C);
    for (int i = 1; i <= 76; i++) begin
      step();
      chk("b2b_busy", {31'b0, busy}, 32'h1);
      if (i == 37) chk("b2b_stop_bit", {31'b0, serial_out}, 32'h1);
      if (i == 38) chk("b2b_second_start", {31'b0, serial_out}, 32'h0);
    end
    wait_idle(200);

    // overflow: sixth byte dropped, sticky flag cleared by a read
    for (int b = 1; b <= 6; b++) bus_write(8'(b));
    bus_read(rd);
    chk("ovf_read1", rd, 32'h40B);
    bus_read(rd);
    chk("ovf_read2", rd, 32'h403);
    wait_idle(400);
    bus_read(rd);
    chk("ovf_done_status", rd, 32'h4);

    // pointer wrap: groups of 3,3,3,1
    nb = 8'h11;
    for (int g = 0; g < 4; g++) begin
      for (int j = 0; j < ((g == 3) ? 1 : 3); j++) begin
        bus_write(nb);
        nb = nb + 8'h27;
      end
      wait_idle(400);
      bus_read(rd);
      chk("wrap_status", rd, 32'h4);
    end

    // reset during DATA bit 3 of an all-zero byte
    bus_write(8'h00);
    repeat (16) step();
    chk("pre_rst_serial", {31'b0, serial_out}, 32'h0);
    #2 resetn = 1'b0;
    model_reset();
    #1;
    chk("rst_mid_serial", {31'b0, serial_out}, 32'h1);
    chk("rst_mid_busy", {31'b0, busy}, 32'h0);
    step();
    resetn = 1'b1;
    bus_read(rd);
    chk("rst_mid_status", rd, 32'h4);
    for (int i = 0; i < 60; i++) begin
      step();
      chk("rst_mid_quiet", {31'b0, serial_out}, 32'h1);
    end

    // random traffic against the model
    for (int i = 0; i < 150; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 6) begin
        bus_write(8'($urandom));
      end else if (r < 8) begin
        bus_read(rd);
      end else begin
        enable    = 1'b0;
        mem_valid = 1'b1;
        mem_wstrb = 4'($urandom);
        mem_wdata = $urandom;
        step();
        mem_valid = 1'b0;
        step();
      end
      repeat ($urandom_range(0, 12)) step();
    end
    wait_idle(500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Memory-mapped UART transmitter for the PicoRV32 peripheral bus, at XXXX_XX40 next to the receiver at XXXX_XX48. CPU writes push bytes into an internal FIFO. A baud-timed state machine drains the FIFO and sends 8N1 frames on `serial_out`, LSB first. CPU reads return a status word, so software can poll for space or completion.

## Interface
- `BAUD_DIVIDER`, 434: clocks per bit (50 MHz / 115200); legal range ≥ 2.
- `FIFO_DEPTH`, 8: FIFO entries; power of two, 2..256.
- `clk`  in  1  system clock.
- `resetn`  in  1  reset, asynchronous, active-low; clock is `clk`.
- `enable`  in  1  address decode select for this block.
- `mem_valid`  in  1  bus request.
- `mem_ready`  out  1  bus acknowledge, one-cycle pulse.
- `mem_instr`  in  1  ignored.
- `mem_wstrb`  in  4  nonzero = write, zero = read.
- `mem_wdata`  in  32  bits [7:0] = byte to send.
- `mem_addr`  in  32  ignored; selection is by `enable` only.
- `mem_rdata`  out  32  status word when `enable`, else 0 (combinational).
- `serial_out`  out  1  UART line; idles high.
- `busy`  out  1  high while the FIFO is non-empty or the FSM is not IDLE.

## Operation
- **Acceptance:** an access is accepted on any edge where `mem_valid & enable & !mem_ready` holds. `mem_ready` goes high the next cycle for exactly one cycle. All side effects occur at the acceptance edge.
- **Write** (`mem_wstrb != 0`): if the FIFO is not full, push `mem_wdata[7:0]`. If full, drop the byte and set sticky `overflow`. Fullness uses the count before any pop in the same cycle, so a write while full is dropped even if a pop happens that cycle.
- **Read** (`mem_wstrb == 0`): has no side effect except clearing `overflow` at the acceptance edge. An overflow set on that same edge wins over the clear.
- **Status word:**
  - bit0 `busy`
  - bit1 `full`
  - bit2 `empty`
  - bit3 `overflow`
  - bits [8+CW-1:8] `count`, where CW = log2(FIFO_DEPTH)+1
  - all other bits 0
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE: `serial_out`=1. When the FIFO is non-empty: pop into `shifter`, clear the baud counter, go to START.
  - START: `serial_out`=0 for one bit time, then go to DATA with `bitcnt`=0.
  - DATA: `serial_out`=`shifter[0]`. At each bit-time end, shift right and increment `bitcnt`. After bit 7, go to STOP.
  - STOP: `serial_out`=1 for one bit time. At its end, if the FIFO is non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- **Baud counter:** counts 0..BAUD_DIVIDER-1 while not IDLE; bit-time end is when count == BAUD_DIVIDER-1. Counter width is 20 bits; BAUD_DIVIDER must be < 2^20.
- **FIFO:** circular read/write pointers of log2(FIFO_DEPTH) bits with natural wrap, plus a separate CW-bit count. A push and a pop in the same cycle leave the count unchanged.
- **`serial_out` drive:** registered, so no glitches.

## Timing
- **Reset values:**
  - `serial_out`=1, `mem_ready`=0, `busy`=0
  - FSM=IDLE, FIFO empty (count 0, pointers 0), `overflow`=0, `shifter`=0
  - `mem_rdata` follows the status word: 0x0000_0004 with `enable` high.
- **Start latency:** a write accepted at edge E into an empty FIFO with the FSM idle pops at E+1 and drives `serial_out` low from E+1. `busy` is high from E.
- **Frame length:** exactly 10×BAUD_DIVIDER clocks. Back-to-back frames are contiguous.
- **Status timing:** status reflects register state; a read returns the values present before the acceptance edge's updates.
- **Reset mid-frame:** `serial_out` returns to 1 asynchronously. FIFO contents are discarded and no partial frame resumes.
- **`mem_valid` held high:** `mem_ready` pulses at most every second cycle. The CPU must drop `mem_valid` after `mem_ready`.

## Structure
- Shared package `uart_pkg`:
  - FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3)
  - status bit positions
  - default BAUD_DIVIDER constant, also used by `uart_rx`
- Sub-module `sync_fifo` (parameters WIDTH=8, DEPTH), with ports `push`, `pop`, `din`, `dout`, `full`, `empty`, `count`. It is reusable for a future RX FIFO.
- The top level holds the bus logic, status/`overflow` register, baud counter and FSM.

## Test plan
All scenarios use BAUD_DIVIDER=4 and FIFO_DEPTH=4.
- **Single byte:** reset, then write 0x55 → `serial_out` low from E+1 for 4 clocks, then bits 1,0,1,0,1,0,1,0 at 4 clocks each, then high for 4 clocks; `busy` drops after 40 clocks; status reads 0x0000_0004.
- **Back-to-back:** write 0xA5 then 0x3C on consecutive accesses → two contiguous 40-clock frames with no idle cycle between the stop bit and the second start bit.
- **Overflow:** six writes 0x01..0x06 issued before the first frame ends → bytes 0x01..0x05 are sent (one popped into the shifter, four held in the FIFO), 0x06 is dropped. A read shows bit3=1 and bit1=1; the next read shows bit3=0.
- **Wrap-around:** send 10 bytes in groups of 3, waiting for empty between groups → every byte is received in order and the pointers wrap without loss.
- **Reset mid-frame:** assert `resetn` low during DATA bit 3 → `serial_out`=1 immediately. After release, status is 0x0000_0004 and no further transitions occur.
- **Bus handshake:** hold `enable`=0 with `mem_valid`=1 → `mem_ready` stays 0 and `mem_rdata`=0. A read with `enable`=1 → `mem_ready` is high exactly one cycle after acceptance.
